// File: rtl/shake256_squeeze.sv
`default_nettype none
// ============================================================================
//  Module   : shake256_squeeze
//  Purpose  : SHAKE256 squeeze engine. Streams the 17-word rate of a permuted
//             1600-bit state over valid/ready and re-runs an external
//             KECCAK_f whenever more words are requested than one block holds.
//  Revision : 1.0  initial release
// ============================================================================
module shake256_squeeze #(
  parameter int LEN_W      = 16,
  parameter int RATE_WORDS = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1599:0]    state_in,
  input  logic [LEN_W-1:0] out_len,
  output logic             busy,
  output logic [63:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done,
  output logic [1599:0]    perm_S_in,
  output logic             perm_reset,
  input  logic [1599:0]    perm_S_out,
  input  logic             perm_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EMIT      = 3'd1,
    S_PERM_LOAD = 3'd2,
    S_PERM_WAIT = 3'd3,
    S_FIN       = 3'd4
  } state_t;

  localparam logic [4:0] c_LAST_IDX = 5'(RATE_WORDS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [1599:0]       r_st;
  logic [1599:0]       r_perm_s_in;
  logic [LEN_W-1:0]    r_rem;
  logic [4:0]          r_idx;
  logic                w_hs;
  logic [1599:0]       w_shifted;

  // A word transfers only while emitting and the sink is ready.
  assign w_hs = (r_state == S_EMIT) && out_ready;

  // Current word is brought to the top of the state by a left shift of 64*idx.
  assign w_shifted = r_st << {r_idx, 6'd0};

  // State register; reset forces IDLE from any state.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic. Completion is tested before the block-boundary case so
  // an exact multiple of the rate ends without an extra permutation.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (out_len == '0) ? S_FIN : S_EMIT;
      end
      S_EMIT: begin
        if (w_hs) begin
          if (r_rem == LEN_W'(1))       w_next = S_FIN;
          else if (r_idx == c_LAST_IDX) w_next = S_PERM_LOAD;
          else                          w_next = S_EMIT;
        end
      end
      S_PERM_LOAD: w_next = S_PERM_WAIT;
      S_PERM_WAIT: begin
        if (perm_done) w_next = S_EMIT;
      end
      S_FIN:       w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Datapath: state capture, word counters and permutation input register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_st        <= '0;
      r_perm_s_in <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_st  <= state_in;
            r_rem <= out_len;
            r_idx <= '0;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            r_rem <= r_rem - LEN_W'(1);
            r_idx <= r_idx + 5'd1;
          end
        end
        S_PERM_LOAD: r_perm_s_in <= r_st;
        S_PERM_WAIT: begin
          if (perm_done) begin
            r_st  <= perm_S_out;
            r_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign out_valid  = (r_state == S_EMIT);
  assign out_data   = out_valid ? w_shifted[1599 -: 64] : 64'd0;
  assign out_last   = out_valid && (r_rem == LEN_W'(1));
  assign done       = (r_state == S_FIN);
  assign perm_S_in  = r_perm_s_in;
  assign perm_reset = (r_state == S_PERM_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_shake256_squeeze.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shake256_squeeze
//  Purpose  : Directed self-checking bench for shake256_squeeze with a
//             behavioural KECCAK_f stand-in (done 24 cycles after release,
//             S_out = ~S_in).
//  Revision : 1.0  initial release
// ============================================================================
module tb_shake256_squeeze;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [1599:0] state_in;
  logic [15:0]   out_len;
  logic          busy;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
  logic [1599:0] perm_S_in;
  logic          perm_reset;
  logic [1599:0] perm_S_out;
  logic          perm_done;

  shake256_squeeze #(.LEN_W(16), .RATE_WORDS(17)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .state_in   (state_in),
    .out_len    (out_len),
    .busy       (busy),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .done       (done),
    .perm_S_in  (perm_S_in),
    .perm_reset (perm_reset),
    .perm_S_out (perm_S_out),
    .perm_done  (perm_done)
  );

  always #5 clock = ~clock;

  // Permutation stand-in: counts while released, done pulses 24 cycles later.
  int r_pcnt = 0;
  logic r_pdone = 1'b0;
  always @(posedge clock) begin
    if (!perm_reset) begin
      r_pcnt  <= 0;
      r_pdone <= 1'b0;
    end else begin
      r_pcnt  <= r_pcnt + 1;
      r_pdone <= (r_pcnt == 23);
    end
  end
  assign perm_done  = r_pdone;
  assign perm_S_out = ~perm_S_in;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor state, sampled on the falling edge.
  logic [63:0]   q_data[$];
  logic          q_last[$];
  int            q_cyc[$];
  int            n_done, done_cyc, n_valid, n_busy, n_prst, prst_cyc;
  logic [1599:0] perm_cap;
  logic          p_valid, p_ready, p_last;
  logic [63:0]   p_data;

  task automatic clear_mon();
    q_data.delete(); q_last.delete(); q_cyc.delete();
    n_done = 0; done_cyc = -1; n_valid = 0; n_busy = 0;
    n_prst = 0; prst_cyc = -1; perm_cap = '0;
  endtask

  always @(negedge clock) begin
    if (out_valid && p_valid && !p_ready) begin
      check("stall_data", out_data, p_data);
      check("stall_last", {63'd0, out_last}, {63'd0, p_last});
    end
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (out_valid) n_valid++;
    if (busy) n_busy++;
    if (perm_reset) begin
      if (n_prst == 0) begin prst_cyc = cyc; perm_cap = perm_S_in; end
      n_prst++;
    end
    p_valid = out_valid; p_ready = out_ready; p_data = out_data; p_last = out_last;
  end

  function automatic logic [63:0] qd(input int i);
    return (i < q_data.size()) ? q_data[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction
  function automatic logic [63:0] ql(input int i);
    return (i < q_last.size()) ? {63'd0, q_last[i]} : 64'hDEAD;
  endfunction
  function automatic int qc(input int i);
    return (i < q_cyc.size()) ? q_cyc[i] : -100;
  endfunction

  function automatic logic [1599:0] stub_state();
    logic [1599:0] s;
    s = '0;
    for (int i = 0; i < 25; i++) s[1599-64*i -: 64] = 64'h0101010101010101 * 64'(i);
    return s;
  endfunction

  function automatic logic rdy(input int mode, input int k);
    logic [5:0] pat;
    pat = 6'b101001;          // k = 0..5 -> 1,0,0,1,0,1
    case (mode)
      1:       return pat[k % 6];
      2:       return (k >= 4);
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  int acc;

  // One transaction: pulse start, drive out_ready per mode, wait for done.
  // Mode 2 also re-pulses start mid-run with a different state.
  task automatic run(input logic [1599:0] st, input logic [1599:0] alt,
                     input int len, input int mode);
    int k;
    clear_mon();
    state_in  = st;
    out_len   = 16'(len);
    start     = 1'b1;
    out_ready = rdy(mode, 0);
    tick();
    acc   = cyc;
    start = 1'b0;
    k     = 0;
    while (n_done == 0 && k < 400) begin
      k++;
      out_ready = rdy(mode, k);
      if (mode == 2 && k == 2) begin
        start = 1'b1; state_in = alt; out_len = 16'd9;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    if (n_done == 0) check("done_timeout", 64'd0, 64'd1);
    start = 1'b0;
    tick(); tick();
    check("done_once", 64'(n_done), 64'd1);
  endtask

  logic [1599:0] st1, stub;

  initial begin
    reset = 1'b0; start = 1'b0; state_in = '0; out_len = '0; out_ready = 1'b0;
    clear_mon();
    tick(); tick();
    check("rst_busy",   {63'd0, busy},       64'd0);
    check("rst_valid",  {63'd0, out_valid},  64'd0);
    check("rst_last",   {63'd0, out_last},   64'd0);
    check("rst_done",   {63'd0, done},       64'd0);
    check("rst_data",   out_data,            64'd0);
    check("rst_prst",   {63'd0, perm_reset}, 64'd0);
    check("rst_psin",   {63'd0, |perm_S_in}, 64'd0);
    reset = 1'b1;
    tick();

    // 1: SHAKE256("") first block, 4 words at full rate
    st1 = '0;
    st1[1599 -: 64] = 64'h46b9dd2b0ba88d13;
    st1[1535 -: 64] = 64'h233b3feb743eeb24;
    st1[1471 -: 64] = 64'h3fcd52ea62b81b82;
    st1[1407 -: 64] = 64'hb50c27646ed5762f;
    run(st1, '0, 4, 0);
    check("t1_cnt", 64'(q_data.size()), 64'd4);
    check("t1_w0", qd(0), 64'h46b9dd2b0ba88d13);
    check("t1_w1", qd(1), 64'h233b3feb743eeb24);
    check("t1_w2", qd(2), 64'h3fcd52ea62b81b82);
    check("t1_w3", qd(3), 64'hb50c27646ed5762f);
    for (int i = 0; i < 4; i++) check("t1_cyc", 64'(qc(i)), 64'(acc + i));
    check("t1_last2", ql(2), 64'd0);
    check("t1_last3", ql(3), 64'd1);
    check("t1_done_cyc", 64'(done_cyc), 64'(acc + 4));
    check("t1_no_perm", 64'(n_prst), 64'd0);

    // 2: exactly one rate block
    stub = stub_state();
    run(stub, '0, 17, 0);
    check("t2_cnt", 64'(q_data.size()), 64'd17);
    for (int i = 0; i < 17; i++) check("t2_w", qd(i), 64'h0101010101010101 * 64'(i));
    check("t2_last15", ql(15), 64'd0);
    check("t2_last16", ql(16), 64'd1);
    check("t2_no_perm", 64'(n_prst), 64'd0);

    // 3: crosses into a second block via the permutation
    run(stub, '0, 20, 0);
    check("t3_cnt", 64'(q_data.size()), 64'd20);
    check("t3_w16", qd(16), 64'h1010101010101010);
    check("t3_gap", 64'(prst_cyc - qc(16)), 64'd2);
    check("t3_psin", {63'd0, perm_cap === stub}, 64'd1);
    check("t3_prst_len", 64'(n_prst), 64'd25);
    check("t3_w17", qd(17), ~64'h0);
    check("t3_w18", qd(18), ~64'h0101010101010101);
    check("t3_w19", qd(19), ~64'h0202020202020202);
    check("t3_last18", ql(18), 64'd0);
    check("t3_last19", ql(19), 64'd1);
    check("t3_w17_cyc", 64'(qc(17) - prst_cyc), 64'd25);

    // 4: back-pressure pattern
    run(stub, '0, 5, 1);
    check("t4_cnt", 64'(q_data.size()), 64'd5);
    for (int i = 0; i < 5; i++) check("t4_w", qd(i), 64'h0101010101010101 * 64'(i));
    check("t4_last4", ql(4), 64'd1);
    check("t4_done_cyc", 64'(done_cyc), 64'(qc(4) + 1));

    // 5: zero-length request
    run(stub, '0, 0, 0);
    check("t5_valid", 64'(n_valid), 64'd0);
    check("t5_busy", 64'(n_busy), 64'd1);
    check("t5_done_cyc", 64'(done_cyc), 64'(acc));

    // 5b: start while busy is ignored
    run(stub, ~stub, 3, 2);
    check("t5b_cnt", 64'(q_data.size()), 64'd3);
    for (int i = 0; i < 3; i++) check("t5b_w", qd(i), 64'h0101010101010101 * 64'(i));
    check("t5b_last", ql(2), 64'd1);

    // 6: reset during PERM_WAIT, then a fresh run
    clear_mon();
    state_in = stub; out_len = 16'd40; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !perm_reset; i++) tick();
    check("t6_in_wait", {63'd0, perm_reset}, 64'd1);
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check("t6_busy",  {63'd0, busy},       64'd0);
    check("t6_valid", {63'd0, out_valid},  64'd0);
    check("t6_done",  {63'd0, done},       64'd0);
    check("t6_data",  out_data,            64'd0);
    check("t6_prst",  {63'd0, perm_reset}, 64'd0);
    check("t6_psin",  {63'd0, |perm_S_in}, 64'd0);
    reset = 1'b1;
    tick();
    run(st1, '0, 2, 0);
    check("t6_cnt", 64'(q_data.size()), 64'd2);
    check("t6_w0", qd(0), 64'h46b9dd2b0ba88d13);
    check("t6_w1", qd(1), 64'h233b3feb743eeb24);
    check("t6_last", ql(1), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
